mcu_core_p: RTL and testbench

MCU_CORE_P -- requirements
Module: mcu_core_p

---
 rtl/mcu_core_p.sv | 205 ++++++++++++++++++++
 tb/tb_mcu_core_p.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_core_p.sv
// Purpose: minimal 8-bit-style accumulator-free MCU core, 4 x DATA_W registers, multi-cycle FSM.
// Latency: 3 cycles per 1-word instruction at zero wait (FETCH, DECODE, EXEC), plus OPND/MEM accesses.
// Backpressure: every access holds mem_req/addr/we/wdata until mem_ready; TIMEOUT wait cycles -> bus_err, ERR.
//
// Ports: clk/rst (async active-low); mem_req/we/addr/wdata/rdata/ready memory bus; in_port/out_port
// I/O; pc, ir, flags {C,V,N,Z}, state code, halted, and sticky inst_err/bus_err for observation.
module mcu_core_p #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}},
    parameter int                TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        flags,
    output logic [2:0]        state,
    output logic              halted,
    output logic              inst_err,
    output logic              bus_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPND   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q, opnd_q, out_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [3:0]        flags_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hold_q;   // forces one idle bus cycle after each completion (and after reset)
    logic              inst_err_q, bus_err_q;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] a_v, b_v, alu_res;
    logic [DATA_W:0]   alu_wide;
    logic              alu_c, alu_v;
    logic [3:0]        alu_flags;
    logic              is_st_io, access, done, stall, timeout;

    assign op     = ir_q[7:4];
    assign rd     = ir_q[3:2];
    assign rs     = ir_q[1:0];
    assign addr_a = opnd_q[ADDR_W-1:0];
    assign a_v    = regs_q[rd];
    assign b_v    = regs_q[rs];

    // A store to the I/O address is handled internally and never reaches the bus.
    assign is_st_io = (op == 4'h2) && (addr_a == IO_ADDR);
    assign access   = (state_q == S_FETCH) || (state_q == S_OPND) ||
                      ((state_q == S_MEM) && !is_st_io);
    assign mem_req  = access && !hold_q;
    assign done     = mem_req && mem_ready;
    assign stall    = mem_req && !mem_ready;
    assign timeout  = stall && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign mem_we    = (state_q == S_MEM) && (op == 4'h2);
    assign mem_addr  = (state_q == S_MEM) ? addr_a : pc_q;
    assign mem_wdata = regs_q[rd];

    assign out_port = out_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign flags    = flags_q;
    assign state    = state_q;
    assign halted   = (state_q == S_HALT);
    assign inst_err = inst_err_q;
    assign bus_err  = bus_err_q;

    // ALU: operands read from the register file before the write, so rd == rs is safe.
    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            4'h3: begin
                alu_wide = {1'b0, a_v} + {1'b0, b_v};
                alu_res  = alu_wide[MSB:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = (a_v[MSB] == b_v[MSB]) && (alu_res[MSB] != a_v[MSB]);
            end
            4'h4: begin
                alu_wide = {1'b0, a_v} - {1'b0, b_v};
                alu_res  = alu_wide[MSB:0];
                alu_c    = alu_wide[DATA_W];   // borrow
                alu_v    = (a_v[MSB] != b_v[MSB]) && (alu_res[MSB] != a_v[MSB]);
            end
            4'h5: alu_res = a_v & b_v;
            4'h6: alu_res = a_v | b_v;
            4'h7: alu_res = a_v ^ b_v;
            default: ;
        endcase
        alu_flags = {alu_c, alu_v, alu_res[MSB], (alu_res == '0)};
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_FETCH: begin
                if (timeout)   state_nxt = S_ERR;
                else if (done) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    4'h1, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD: state_nxt = S_OPND;
                    4'hE:    state_nxt = S_HALT;
                    4'hF:    state_nxt = S_ERR;
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_OPND: begin
                if (timeout)   state_nxt = S_ERR;
                else if (done) state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = ((op == 4'h1) || (op == 4'h2)) ? S_MEM : S_FETCH;
            S_MEM: begin
                if (is_st_io)     state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_ERR;
                else if (done)    state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            ir_q       <= '0;
            opnd_q     <= '0;
            out_q      <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= 1'b1;
            inst_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            hold_q <= done;
            if (done)       cnt_q <= '0;
            else if (stall) cnt_q <= cnt_q + CNT_W'(1);
            if (timeout)    bus_err_q <= 1'b1;

            case (state_q)
                S_FETCH: if (done) begin
                    ir_q <= mem_rdata;
                    pc_q <= pc_q + ADDR_W'(1);
                end
                S_DECODE: if (op == 4'hF) inst_err_q <= 1'b1;
                S_OPND: if (done) begin
                    opnd_q <= mem_rdata;
                    pc_q   <= pc_q + ADDR_W'(1);
                end
                S_EXEC: begin
                    case (op)
                        4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            regs_q[rd] <= alu_res;
                            flags_q    <= alu_flags;
                        end
                        4'h8: regs_q[rd] <= in_port;
                        4'h9: regs_q[rd] <= regs_q[rs];
                        4'hA: regs_q[rd] <= opnd_q;
                        4'hB: pc_q <= addr_a;
                        4'hC: if (flags_q[0]) pc_q <= addr_a;
                        4'hD: if (flags_q[1]) pc_q <= addr_a;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (is_st_io)                    out_q      <= regs_q[rd];
                    else if (done && (op == 4'h1))   regs_q[rd] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_core_p.sv
module tb_mcu_core_p;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_req, mem_we, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, in_port, out_port, pc, ir;
    logic [3:0] flags;
    logic [2:0] state;
    logic       halted, inst_err, bus_err;

    mcu_core_p dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .in_port(in_port), .out_port(out_port),
        .pc(pc), .ir(ir), .flags(flags), .state(state), .halted(halted),
        .inst_err(inst_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [7:0]  mem [256];
    int          run = 0, req_cycles = 0, cur_delay = 0, fix_delay = 0;
    bit          rand_delay = 0, never_ready = 0, prev_done = 0, seen_first = 0, saw_wrap = 0;
    logic [7:0]  hold_addr = 0, first_addr = 0, last_rd = 0;
    logic        hold_we = 0, first_we = 0;
    logic [15:0] act_wq [$];

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        in_port   = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            mem_ready  = 1'b0;
            run        = 0;
            prev_done  = 0;
            seen_first = 0;
            req_cycles = 0;
        end else begin
            if (prev_done) chk("req_gap", mem_req, 0);
            prev_done = 0;
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                req_cycles++;
                if (run > 0) begin
                    chk("addr_stable", mem_addr, hold_addr);
                    chk("we_stable", mem_we, hold_we);
                end else begin
                    hold_addr = mem_addr;
                    hold_we   = mem_we;
                    cur_delay = rand_delay ? $urandom_range(0, 3) : fix_delay;
                    if (!seen_first) begin
                        first_addr = mem_addr;
                        first_we   = mem_we;
                        seen_first = 1;
                    end
                end
                if (!never_ready && run >= cur_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        act_wq.push_back({mem_addr, mem_wdata});
                    end else begin
                        if (mem_addr == 8'h00 && last_rd == 8'hFF) saw_wrap = 1;
                        last_rd = mem_addr;
                    end
                    run       = 0;
                    prev_done = 1;
                end else begin
                    run++;
                end
            end else begin
                if (run > 0 && !never_ready) chk("req_held", mem_req, 1);
                run = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    int wp = 0;

    task automatic put(input int b);
        mem[wp] = 8'(b);
        wp++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wp = 0;
        act_wq.delete();
        saw_wrap = 0;
        last_rd  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_stop(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted || state == 3'd6) begin
                ok = 1;
                break;
            end
        end
        chk("run_done", ok, 1);
    endtask

    // ---------------- instruction-level reference model ----------------
    int          exp_pc, exp_out, exp_state;
    logic [3:0]  exp_flags;
    logic [15:0] exp_wq [$];

    task automatic model_run();
        int mm [256];
        int rg [4];
        int p, w, op, rd, rs, ad, a, b, r;
        bit c, v, n, z;
        for (int i = 0; i < 256; i++) mm[i] = int'(mem[i]);
        for (int i = 0; i < 4; i++) rg[i] = 0;
        p = 0; c = 0; v = 0; n = 0; z = 0; ad = 0;
        exp_wq.delete();
        exp_out = 0;
        exp_state = 0;
        for (int step = 0; step < 2000 && exp_state == 0; step++) begin
            w = mm[p]; p = (p + 1) % 256;
            op = w / 16; rd = (w / 4) % 4; rs = w % 4;
            if (op inside {1, 2, 10, 11, 12, 13}) begin
                ad = mm[p]; p = (p + 1) % 256;
            end
            a = rg[rd]; b = rg[rs];
            case (op)
                1: rg[rd] = mm[ad];
                2: if (ad == 255) exp_out = a;
                   else begin mm[ad] = a; exp_wq.push_back(16'(ad * 256 + a)); end
                3: begin r = a + b; c = (r > 255); r = r % 256;
                         v = (a < 128) == (b < 128) && (r < 128) != (a < 128);
                         rg[rd] = r; z = (r == 0); n = (r >= 128); end
                4: begin c = (a < b); r = (a - b + 256) % 256;
                         v = (a < 128) != (b < 128) && (r < 128) != (a < 128);
                         rg[rd] = r; z = (r == 0); n = (r >= 128); end
                5, 6, 7: begin
                         r = (op == 5) ? (a & b) : (op == 6) ? (a | b) : (a ^ b);
                         c = 0; v = 0; rg[rd] = r; z = (r == 0); n = (r >= 128); end
                8: rg[rd] = int'(in_port);
                9: rg[rd] = b;
                10: rg[rd] = ad;
                11: p = ad;
                12: if (z) p = ad;
                13: if (n) p = ad;
                14: exp_state = 5;
                15: exp_state = 6;
                default: ;
            endcase
        end
        exp_pc    = p;
        exp_flags = {c, v, n, z};
    endtask

    task automatic gen_random_prog();
        int k, rd, op;
        clear_mem();
        for (int i = 128; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin put(8'hA0 | (i << 2)); put($urandom_range(0, 255)); end
        for (int i = 0; i < 15; i++) begin
            k  = $urandom_range(0, 9);
            rd = $urandom_range(0, 3);
            case (k)
                0: begin put(8'hA0 | (rd << 2)); put($urandom_range(0, 255)); end
                3: put(8'h80 | (rd << 2));
                4: put(8'h90 | $urandom_range(0, 15));
                5: begin put(8'h20 | (rd << 2)); put($urandom_range(128, 254)); end
                6: begin put(8'h10 | (rd << 2)); put($urandom_range(128, 254)); end
                7: begin
                    op = $urandom_range(12, 13);
                    put((op << 4)); put(wp + 2);
                    put(((3 + $urandom_range(0, 4)) << 4) | $urandom_range(0, 15));
                end
                8: put(8'h00);
                default: put(((3 + $urandom_range(0, 4)) << 4) | $urandom_range(0, 15));
            endcase
        end
        for (int i = 0; i < 4; i++) begin put(8'h20 | (i << 2)); put(8'hF0 + i); end
        put(8'h20 | ($urandom_range(0, 3) << 2)); put(8'hFF);
        put(8'hE0);
    endtask

    task automatic load_basic_prog();
        clear_mem();
        put(8'hA0); put(8'h05); put(8'hA4); put(8'h03);
        put(8'h31); put(8'h20); put(8'hFF); put(8'hE0);
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_out"}, out_port, 8'h08);
        chk({tag, "_flags"}, flags, 4'h0);
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_pc"}, pc, 8'h08);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset state
        clear_mem();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_state", state, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out", out_port, 0);
        chk("rst_errs", {halted, inst_err, bus_err}, 0);

        // Basic program, zero wait
        load_basic_prog();
        rand_delay = 0; fix_delay = 0; never_ready = 0;
        do_reset();
        run_until_stop(500);
        check_basic("basic0");
        chk("basic0_first_addr", first_addr, 0);

        // Same program, 3 wait cycles per access
        load_basic_prog();
        fix_delay = 3;
        do_reset();
        run_until_stop(1000);
        check_basic("basic3");

        // Signed overflow on ADD
        clear_mem();
        put(8'hA0); put(8'h7F); put(8'hA4); put(8'h01); put(8'h31);
        put(8'h20); put(8'hFF); put(8'hE0);
        fix_delay = 0;
        do_reset();
        run_until_stop(500);
        chk("ovf_out", out_port, 8'h80);
        chk("ovf_flags", flags, 4'b0110);

        // SUB with rd == rs
        clear_mem();
        put(8'hA8); put(8'h09); put(8'h4A); put(8'hE0);
        do_reset();
        run_until_stop(500);
        chk("subeq_flags", flags, 4'b0001);

        // Illegal opcode
        clear_mem();
        put(8'hF0);
        do_reset();
        run_until_stop(200);
        chk("ill_inst_err", inst_err, 1);
        chk("ill_state", state, 6);
        chk("ill_pc", pc, 1);
        chk("ill_halted", halted, 0);

        // Jump to the top address, wrap to 0
        clear_mem();
        put(8'hD0); put(8'h20); put(8'hA0); put(8'h80); put(8'h60); put(8'hB0); put(8'hFF);
        mem[8'h20] = 8'h20; mem[8'h21] = 8'hFF; mem[8'h22] = 8'hE0; mem[8'hFF] = 8'h00;
        do_reset();
        run_until_stop(500);
        chk("wrap_seen", saw_wrap, 1);
        chk("wrap_out", out_port, 8'h80);
        chk("wrap_pc", pc, 8'h23);
        chk("wrap_flags", flags, 4'b0010);

        // Memory never ready -> bus error
        clear_mem();
        never_ready = 1;
        do_reset();
        run_until_stop(200);
        chk("to_bus_err", bus_err, 1);
        chk("to_state", state, 6);
        chk("to_req_cycles", req_cycles, 15);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req_low", mem_req, 0);
        end
        never_ready = 0;

        // Reset pulse during an operand wait
        load_basic_prog();
        fix_delay = 10;
        do_reset();
        begin
            bit got = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (state == 3'd2 && mem_req) begin got = 1; break; end
            end
            chk("opnd_reached", got, 1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_ir", ir, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_misc", {flags, out_port, halted, inst_err, bus_err}, 0);
        fix_delay = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_until_stop(500);
        chk("restart_first_addr", first_addr, 0);
        chk("restart_first_we", first_we, 0);
        check_basic("restart");

        // Randomized programs against the reference model
        rand_delay = 1;
        for (int t = 0; t < 8; t++) begin
            gen_random_prog();
            in_port = 8'($urandom);
            model_run();
            do_reset();
            run_until_stop(4000);
            chk("rnd_state", state, exp_state);
            chk("rnd_out", out_port, exp_out);
            chk("rnd_flags", flags, exp_flags);
            chk("rnd_pc", pc, exp_pc);
            chk("rnd_errs", {inst_err, bus_err}, 0);
            chk("rnd_nwrites", act_wq.size(), exp_wq.size());
            for (int i = 0; i < exp_wq.size() && i < act_wq.size(); i++)
                chk("rnd_write", act_wq[i], exp_wq[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
